data_mem_ctrl: RTL and testbench

//  Data-memory stage downstream of the CPU data MAR: consumes the 8-bit data address and the read/write strobes, and holds a 2**ADDR_W x DATA_W RAM.

---
 rtl/data_mem_ctrl_if.sv | 40 ++++
 rtl/data_mem_ctrl.sv | 136 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_if
//   Request/response bundle between the CPU data MAR side and the data-memory
//   stage.
//   master : drives addr, rd, wr, data_in; observes the response signals
//   slave  : the memory stage; drives data_out, data_oe, ready, busy, wr_fault
// Signals
//   addr     [ADDR_W]  data address
//   rd, wr             level request strobes, held until ready
//   data_in  [DATA_W]  write data
//   data_out [DATA_W]  read data register
//   data_oe            data_out is valid for the bus this cycle
//   ready              one-cycle access-complete pulse
//   busy               an access is in progress
//   wr_fault           write to a protected address was dropped
// -----------------------------------------------------------------------------
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              ready;
  logic              busy;
  logic              wr_fault;

  modport master (
    output addr, rd, wr, data_in,
    input  data_out, data_oe, ready, busy, wr_fault
  );

  modport slave (
    input  addr, rd, wr, data_in,
    output data_out, data_oe, ready, busy, wr_fault
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Data-memory stage behind the CPU data MAR. Holds a 2**ADDR_W x DATA_W RAM,
//   inserts WAIT_CYCLES wait states before each array access and answers every
//   accepted request with a one-cycle ready pulse. Read data is registered on
//   data_out and flagged with data_oe for the top level to drive onto DATA_BUS.
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high; RAM contents are kept
//   bus    data_mem_ctrl_if.slave (addr, rd, wr, data_in, data_out, data_oe,
//          ready, busy, wr_fault)
// Configuration
//   DMEM_PROTECT_EN  when defined, writes to addresses >= PROT_BASE complete
//                    the handshake without touching the RAM and pulse
//                    wr_fault with ready. When undefined wr_fault stays 0.
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] PROT_BASE   = 'hF0
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_ctrl_if.slave       bus
);

`ifdef DMEM_PROTECT_EN
  localparam logic PROTECT_EN = 1'b1;
`else
  localparam logic PROTECT_EN = 1'b0;
`endif

  // Counter preload: WAIT_CYCLES-1 so that ACCESS is entered exactly
  // WAIT_CYCLES edges after acceptance.
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              op_wr_q, op_wr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              prot_hit;
  logic              mem_we;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Protection only ever applies to writes; constant-folds away when disabled.
  assign prot_hit = PROTECT_EN && op_wr_q && (addr_q >= PROT_BASE);

  // Reset wins over the ACCESS exit edge, so an abandoned write never lands.
  assign mem_we = (state_q == ACCESS) && op_wr_q && !prot_hit && !reset;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_wr_d    = op_wr_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        if (bus.rd || bus.wr) begin
          addr_d  = bus.addr;
          wdata_d = bus.data_in;
          op_wr_d = bus.wr;          // rd and wr together count as a write
          if (WAIT_CYCLES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: begin
        if (!op_wr_q) begin
          data_out_d = mem[addr_q];
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Request latches only matter while an access is in flight, so no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    op_wr_q <= op_wr_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.ready    = (state_q == DONE);
  assign bus.data_oe  = (state_q == DONE) && !op_wr_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.wr_fault = (state_q == DONE) && prot_hit;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Directed bench for data_mem_ctrl. dut_a runs with WAIT_CYCLES=2,
//   dut_b with WAIT_CYCLES=0; both share clk and reset.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errs = 0;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(8), .DATA_W(16)) ifa ();
  data_mem_ctrl_if #(.ADDR_W(8), .DATA_W(16)) ifb ();

  data_mem_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2), .PROT_BASE(8'hF0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  data_mem_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0), .PROT_BASE(8'hF0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit r, input bit w, input logic [7:0] a, input logic [15:0] d);
    if (sel) begin
      ifb.rd = r; ifb.wr = w; ifb.addr = a; ifb.data_in = d;
    end else begin
      ifa.rd = r; ifa.wr = w; ifa.addr = a; ifa.data_in = d;
    end
  endtask

  // One full handshake. a2/d2 replace addr/data_in right after acceptance.
  // lat counts edges from acceptance to the edge after which ready is seen.
  task automatic do_acc(input bit sel, input bit r, input bit w,
                        input logic [7:0] a, input logic [15:0] d,
                        input logic [7:0] a2, input logic [15:0] d2,
                        output int lat, output logic [15:0] q,
                        output logic oe, output logic flt);
    bit seen;
    @(negedge clk);
    drive(sel, r, w, a, d);
    @(posedge clk);
    #1;
    drive(sel, r, w, a2, d2);
    lat = 0; seen = 0; q = '0; oe = 1'b0; flt = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (sel ? ifb.ready : ifa.ready) begin
        seen = 1;
        q    = sel ? ifb.data_out : ifa.data_out;
        oe   = sel ? ifb.data_oe  : ifa.data_oe;
        flt  = sel ? ifb.wr_fault : ifa.wr_fault;
        drive(sel, 1'b0, 1'b0, a2, d2);
      end
    end
    if (!seen) begin
      lat = -1;
      drive(sel, 1'b0, 1'b0, a2, d2);
    end
    @(posedge clk);
    #1;
    check("ready_pulse_end", sel ? ifb.ready : ifa.ready, 0);
    check("oe_pulse_end", sel ? ifb.data_oe : ifa.data_oe, 0);
  endtask

  task automatic t_write(input bit sel, input string tag, input logic [7:0] a, input logic [15:0] d,
                         input int exp_lat, input bit exp_flt);
    int lat; logic [15:0] q; logic oe, flt;
    do_acc(sel, 1'b0, 1'b1, a, d, a, d, lat, q, oe, flt);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_oe"}, oe, 0);
    check({tag, "_flt"}, flt, exp_flt);
  endtask

  task automatic t_read(input bit sel, input string tag, input logic [7:0] a,
                        input logic [15:0] exp_q, input int exp_lat);
    int lat; logic [15:0] q; logic oe, flt;
    do_acc(sel, 1'b1, 1'b0, a, 16'h0000, a, 16'h0000, lat, q, oe, flt);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, q, exp_q);
    check({tag, "_oe"}, oe, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat; logic [15:0] q; logic oe, flt;
    bit got_ready;

    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ifa.ready, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_data_out", ifa.data_out, 0);
    check("rst_oe", ifa.data_oe, 0);
    check("rst_fault", ifa.wr_fault, 0);
    check("rst_b_data_out", ifb.data_out, 0);
    @(negedge clk);
    reset = 1'b0;

    // WAIT_CYCLES=2 write then read
    t_write(0, "w10", 8'h10, 16'hBEEF, 3, 0);
    t_read(0, "r10", 8'h10, 16'hBEEF, 3);

    // rd and wr together is a write; write leaves data_out alone
    do_acc(0, 1'b1, 1'b1, 8'h20, 16'h1234, 8'h20, 16'h1234, lat, q, oe, flt);
    check("rw20_lat", lat, 3);
    check("rw20_oe", oe, 0);
    check("rw20_hold", ifa.data_out, 16'hBEEF);
    t_read(0, "r20", 8'h20, 16'h1234, 3);

    // addr/data changes during WAIT are ignored
    t_write(0, "w31", 8'h31, 16'h7777, 3, 0);
    do_acc(0, 1'b0, 1'b1, 8'h30, 16'h3030, 8'h31, 16'h9999, lat, q, oe, flt);
    check("w30_lat", lat, 3);
    t_read(0, "r30", 8'h30, 16'h3030, 3);
    t_read(0, "r31", 8'h31, 16'h7777, 3);

    // WAIT_CYCLES=0 at both address extremes
    t_write(1, "b_w00", 8'h00, 16'h0001, 1, 0);
    t_write(1, "b_wff", 8'hFF, 16'h8000, 1, 0);
    t_read(1, "b_r00", 8'h00, 16'h0001, 1);
    t_read(1, "b_rff", 8'hFF, 16'h8000, 1);

    // Write protection boundary
`ifdef DMEM_PROTECT_EN
    do_acc(0, 1'b1, 1'b0, 8'hF0, 16'h0000, 8'hF0, 16'h0000, lat, q, oe, flt);
    t_write(0, "prot_wf0", 8'hF0, 16'h5555, 3, 1);
    t_read(0, "prot_rf0", 8'hF0, q, 3);
`else
    t_write(0, "wf0", 8'hF0, 16'h5555, 3, 0);
    t_read(0, "rf0", 8'hF0, 16'h5555, 3);
`endif
    t_write(0, "wef", 8'hEF, 16'h6666, 3, 0);
    t_read(0, "ref", 8'hEF, 16'h6666, 3);

    // Reset during WAIT abandons the write
    t_write(0, "w40", 8'h40, 16'h0F0F, 3, 0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 8'h40, 16'hAAAA);
    @(posedge clk);
    #1;
    check("rstw_busy", ifa.busy, 1);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h40, 16'hAAAA);
    @(posedge clk);
    #1;
    check("rstw_ready", ifa.ready, 0);
    check("rstw_busy_clr", ifa.busy, 0);
    check("rstw_data_out", ifa.data_out, 0);
    check("rstw_oe", ifa.data_oe, 0);
    check("rstw_fault", ifa.wr_fault, 0);
    @(negedge clk);
    reset = 1'b0;
    got_ready = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (ifa.ready) got_ready = 1;
    end
    check("rstw_no_ready", got_ready, 0);
    t_read(0, "rstw_r40", 8'h40, 16'h0F0F, 3);

    // Reset during ACCESS wins over its exit edge
    t_write(0, "w41", 8'h41, 16'h1111, 3, 0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 8'h41, 16'hCCCC);
    repeat (3) @(posedge clk);
    #1;
    check("rsta_in_access", ifa.busy, 1);
    check("rsta_no_ready_yet", ifa.ready, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h41, 16'hCCCC);
    @(posedge clk);
    #1;
    check("rsta_ready", ifa.ready, 0);
    check("rsta_busy", ifa.busy, 0);
    @(negedge clk);
    reset = 1'b0;
    t_read(0, "rsta_r41", 8'h41, 16'h1111, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
